axis_msg_upsizer: RTL and testbench
===================================

Name: axis_msg_upsizer

Overview:
- Upstream neighbour of the SHA-2 hash engine: gathers a narrow host AXI-Stream (64-bit default) into full 512-bit beats for the engine's slave port.
- Packs beats LSB-first with tkeep and tuser, closing each output word on a full word or on tlast.
- Supports full-rate streaming: a new input beat is accepted in the same cycle a completed word is handed off.

Parameters:
- S_AXIS_DATA_WIDTH, 64, input data width; must divide M_AXIS_DATA_WIDTH; power of two, at least 8.
- M_AXIS_DATA_WIDTH, 512, output data width (engine block width).
- S_AXIS_TUSER_WIDTH, 128, input tuser width.
- M_AXIS_TUSER_WIDTH, 128, output tuser width; must equal S_AXIS_TUSER_WIDTH.

Ports:
- axis_aclk  in  1  single clock; all logic on the rising edge.
- axis_reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  S_AXIS_DATA_WIDTH  input message bytes.
- s_axis_tkeep  in  S_AXIS_DATA_WIDTH/8  byte enables.
- s_axis_tuser  in  S_AXIS_TUSER_WIDTH  per-message metadata.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last beat of message.
- m_axis_tdata  out  M_AXIS_DATA_WIDTH  packed word.
- m_axis_tkeep  out  M_AXIS_DATA_WIDTH/8  packed byte enables.
- m_axis_tuser  out  M_AXIS_TUSER_WIDTH  tuser of the first beat of the word.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  word closes a message.
- sparse_err  out  1  sticky flag: a non-last input beat had tkeep not all ones.

Behaviour:
- RATIO = M_AXIS_DATA_WIDTH/S_AXIS_DATA_WIDTH (8 at defaults). Beat counter cnt is 0..RATIO-1, width clog2(RATIO).
- Reset, while axis_reset is high at a clock edge:
  - cnt = 0; state FILL.
  - m_axis_tvalid/tlast/tdata/tkeep/tuser and sparse_err all 0.
  - s_axis_tready is held 0 combinationally while axis_reset is high.
  - Reset mid-word discards the partial accumulation. Reset while a word is held drops that word without handshake.
- s_axis_tready = !axis_reset && (state==FILL || m_axis_tready).
- Input accept means s_axis_tvalid && s_axis_tready. On accept:
  - tdata is written to bits [cnt*S +: S]; tkeep to bits [cnt*S/8 +: S/8].
  - If cnt==0: the tkeep and tdata registers above the written lane are cleared to 0 and tuser is latched. tuser on later beats is ignored.
  - Closing beat means s_axis_tlast==1 or cnt==RATIO-1. A closing beat sets m_axis_tvalid=1 next cycle, m_axis_tlast=s_axis_tlast, state HOLD, cnt=0. Otherwise cnt++.
  - Latency: the word is valid on the cycle after the closing beat is accepted.
- State FILL: m_axis_tvalid=0; collecting beats.
- State HOLD: m_axis_tvalid=1; tdata/tkeep/tuser/tlast stable until m_axis_tready.
  - tready and no input accept: tvalid falls, state FILL.
  - tready and input accept in the same cycle: that beat starts the next word at lane 0. If it is itself closing (RATIO==1 impossible; tlast-only), stay in HOLD with the new word.
  - !tready: s_axis_tready=0; no input is consumed.
- Short message: tlast at cnt<RATIO-1 emits the word with upper lanes tdata=0, tkeep=0.
- Empty-keep last beat (tkeep=0, tlast=1) is legal and is packed as-is. At cnt==0 this yields a word with tkeep=0 and tlast=1, which marks an empty message for the padder.
- sparse_err is set on accept of a beat with tlast=0 and tkeep not all ones. The data is still packed verbatim, with no compaction. The flag clears only on reset.
- m_axis_tvalid never depends combinationally on m_axis_tready. s_axis_tready may depend combinationally on m_axis_tready.

Decomposition:
- Shared package sha2_axis_pkg holds:
  - BLOCK_DATA_WIDTH=512 and WORDS_DATA_WIDTH=64, shared with the engine.
  - Default TUSER width 128.
  - Localparam function for clog2.
  - Enum for upsizer state {FILL, HOLD}.
- No sub-module: lane-write decode, counter and FSM stay in one module of roughly 150-200 lines.

Test Plan:
- Full word: 8 beats, data 64'h0706050403020100+k*64'h0808080808080808, tkeep=8'hFF, tlast on beat 8, tready=1 -> one word with tdata bytes 0x00..0x3F ascending from LSB, tkeep all ones, tlast=1, tvalid on the cycle after beat 8.
- Short message "abc": one beat, tdata=64'h636261, tkeep=8'h07, tlast=1, tuser=128'hA5 -> tdata=512'h636261, tkeep=64'h7, tlast=1, tuser=128'hA5.
- Multi-word message: 20 beats, tlast on 20, with tuser changing every beat -> 3 words with tlast 0,0,1. Word 3 has tkeep=64'hFFFF_FFFF and the upper 256 bits zero. tuser of each word equals the tuser of beats 1, 9 and 17.
- Backpressure: hold m_axis_tready=0 for 5 cycles after a word completes -> s_axis_tready=0 throughout and outputs stable. On release, the next beat is accepted in the same cycle as the handoff, with no gap cycle at sustained input.
- Sparse/empty: a non-last beat with tkeep=8'h0F -> sparse_err=1 and stays set. A lone beat with tkeep=0 and tlast=1 -> word with tkeep=0 and tlast=1.
- Reset mid-word: 3 beats in, then axis_reset for 1 cycle, then a 1-beat message -> only the new word appears, in lane 0, and all outputs are 0 during reset.

Source files
------------

// File: rtl/sha2_axis_pkg.sv
// Shared definitions between the SHA-2 engine and its AXI-Stream front end.
package sha2_axis_pkg;

    localparam int BLOCK_DATA_WIDTH = 512;
    localparam int WORDS_DATA_WIDTH = 64;
    localparam int TUSER_WIDTH_DEF  = 128;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } upsizer_state_t;

endpackage

// File: rtl/axis_msg_upsizer_if.sv
// AXI-Stream bundle with tkeep/tuser/tlast, used on both sides of the upsizer.
interface axis_msg_upsizer_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int TUSER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_msg_upsizer.sv
// Packs narrow host beats LSB-first into engine-width words, closing on a full word or tlast.
//
//   state | meaning
//   FILL  | collecting beats into the word register, m_axis.tvalid low
//   HOLD  | completed word presented, stable until m_axis.tready
module axis_msg_upsizer
    import sha2_axis_pkg::*;
#(
    parameter int S_AXIS_DATA_WIDTH  = WORDS_DATA_WIDTH,
    parameter int M_AXIS_DATA_WIDTH  = BLOCK_DATA_WIDTH,
    parameter int S_AXIS_TUSER_WIDTH = TUSER_WIDTH_DEF,
    parameter int M_AXIS_TUSER_WIDTH = TUSER_WIDTH_DEF
) (
    input  logic                      axis_aclk,
    input  logic                      axis_reset,
    axis_msg_upsizer_if.slave         s_axis,
    axis_msg_upsizer_if.master        m_axis,
    output logic                      sparse_err
);

    localparam int RATIO  = M_AXIS_DATA_WIDTH / S_AXIS_DATA_WIDTH;
    localparam int CNT_W  = (RATIO > 1) ? clog2(RATIO) : 1;
    localparam int S_KEEP = S_AXIS_DATA_WIDTH / 8;
    localparam int M_KEEP = M_AXIS_DATA_WIDTH / 8;

    if ((M_AXIS_DATA_WIDTH % S_AXIS_DATA_WIDTH) != 0 || S_AXIS_DATA_WIDTH < 8 ||
        (S_AXIS_DATA_WIDTH & (S_AXIS_DATA_WIDTH - 1)) != 0 ||
        M_AXIS_TUSER_WIDTH != S_AXIS_TUSER_WIDTH) begin : g_bad_params
        $error("axis_msg_upsizer: unsupported width parameters");
    end

    upsizer_state_t                state_q;
    logic [CNT_W-1:0]              cnt_q;
    logic [M_AXIS_DATA_WIDTH-1:0]  data_q;
    logic [M_KEEP-1:0]             keep_q;
    logic [S_AXIS_TUSER_WIDTH-1:0] user_q;
    logic                          last_q;
    logic                          valid_q;
    logic                          sparse_q;

    logic                          s_ready;
    logic                          accept;
    logic                          closing;
    logic                          handoff;
    logic [M_AXIS_DATA_WIDTH-1:0]  data_next;
    logic [M_KEEP-1:0]             keep_next;

    // Ready may follow m_axis.tready combinationally so a held word and a new beat can swap in one cycle.
    assign s_ready = !axis_reset && (state_q == FILL || m_axis.tready);
    assign accept  = s_axis.tvalid && s_ready;
    assign closing = s_axis.tlast || (cnt_q == CNT_W'(RATIO - 1));
    assign handoff = (state_q == HOLD) && m_axis.tready;

    // Lane 0 starts a fresh word, so everything above it is cleared rather than carried over.
    always_comb begin
        data_next = (cnt_q == '0) ? '0 : data_q;
        keep_next = (cnt_q == '0) ? '0 : keep_q;
        for (int i = 0; i < RATIO; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                data_next[i*S_AXIS_DATA_WIDTH +: S_AXIS_DATA_WIDTH] = s_axis.tdata;
                keep_next[i*S_KEEP +: S_KEEP]                       = s_axis.tkeep;
            end
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state_q  <= FILL;
            cnt_q    <= '0;
            data_q   <= '0;
            keep_q   <= '0;
            user_q   <= '0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            sparse_q <= 1'b0;
        end else begin
            if (handoff) begin
                valid_q <= 1'b0;
                state_q <= FILL;
            end
            if (accept) begin
                data_q <= data_next;
                keep_q <= keep_next;
                if (cnt_q == '0) begin
                    user_q <= s_axis.tuser;
                end
                if (!s_axis.tlast && !(&s_axis.tkeep)) begin
                    sparse_q <= 1'b1;
                end
                if (closing) begin
                    valid_q <= 1'b1;
                    last_q  <= s_axis.tlast;
                    state_q <= HOLD;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = data_q;
    assign m_axis.tkeep  = keep_q;
    assign m_axis.tuser  = user_q;
    assign m_axis.tlast  = last_q;
    assign m_axis.tvalid = valid_q;
    assign sparse_err    = sparse_q;

endmodule

// File: tb/tb_axis_msg_upsizer.sv
// Directed bench for axis_msg_upsizer with a queue-based scoreboard on the output port.
module tb_axis_msg_upsizer;

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic [127:0] user;
        logic         last;
    } word_t;

    localparam logic [63:0] BASE = 64'h0706050403020100;
    localparam logic [63:0] INC  = 64'h0808080808080808;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sparse_err;

    axis_msg_upsizer_if #(.DATA_WIDTH(64),  .TUSER_WIDTH(128)) s_if ();
    axis_msg_upsizer_if #(.DATA_WIDTH(512), .TUSER_WIDTH(128)) m_if ();

    axis_msg_upsizer #(
        .S_AXIS_DATA_WIDTH (64),
        .M_AXIS_DATA_WIDTH (512),
        .S_AXIS_TUSER_WIDTH(128),
        .M_AXIS_TUSER_WIDTH(128)
    ) dut (
        .axis_aclk (clk),
        .axis_reset(rst),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .sparse_err(sparse_err)
    );

    always #5 clk = ~clk;

    word_t exp_q[$];
    int    n_cmp  = 0;
    int    n_err  = 0;
    int    acc_cnt = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] bytes_seq(input int start, input int n);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i*8 +: 8] = 8'(start + i);
        return r;
    endfunction

    function automatic word_t mk(input logic [511:0] d, input logic [63:0] k,
                                 input logic [127:0] u, input logic l);
        word_t w;
        w.data = d; w.keep = k; w.user = u; w.last = l;
        return w;
    endfunction

    always @(posedge clk) begin
        if (s_if.tvalid && s_if.tready) acc_cnt++;
    end

    // Monitor: every output handshake pops one expected word.
    always @(negedge clk) begin
        word_t w;
        #2;
        if (!rst && m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", m_if.tdata, '0);
            end else begin
                w = exp_q.pop_front();
                chk("word_tdata", m_if.tdata, w.data);
                chk("word_tkeep", m_if.tkeep, w.keep);
                chk("word_tuser", m_if.tuser, w.user);
                chk("word_tlast", m_if.tlast, w.last);
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic [7:0] k,
                        input logic [127:0] u, input logic l);
        int   t;
        logic rdy;
        t = 0;
        @(negedge clk);
        s_if.tdata = d; s_if.tkeep = k; s_if.tuser = u; s_if.tlast = l; s_if.tvalid = 1'b1;
        forever begin
            #1 rdy = s_if.tready;
            @(posedge clk);
            if (rdy) break;
            t++;
            if (t > 100) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: beat %0h not accepted after %0d cycles", d, t);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_tvalid"}, m_if.tvalid, 0);
        chk({tag, "_tdata"},  m_if.tdata,  0);
        chk({tag, "_tkeep"},  m_if.tkeep,  0);
        chk({tag, "_tuser"},  m_if.tuser,  0);
        chk({tag, "_tlast"},  m_if.tlast,  0);
        chk({tag, "_sparse"}, sparse_err,  0);
        chk({tag, "_s_tready"}, s_if.tready, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int t;
        s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0; s_if.tlast = 1'b0; s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1 chk_outputs_zero("reset");
        @(negedge clk) rst = 1'b0;

        // Full word, bytes 0x00..0x3F
        exp_q.push_back(mk(bytes_seq(0, 64), '1, 128'h1234, 1'b1));
        for (int k = 0; k < 8; k++) begin
            send(BASE + 64'(k) * INC, 8'hFF, 128'h1234, k == 7);
            if (k == 6) begin
                #1 chk("valid_before_close", m_if.tvalid, 0);
            end
        end
        #1 chk("valid_after_close", m_if.tvalid, 1);
        idle();

        // Short "abc"
        exp_q.push_back(mk(512'h636261, 64'h7, 128'hA5, 1'b1));
        send(64'h636261, 8'h07, 128'hA5, 1'b1);
        idle();

        // 20-beat message, tuser changes every beat
        exp_q.push_back(mk(bytes_seq(0, 64),   '1,            128'h1000, 1'b0));
        exp_q.push_back(mk(bytes_seq(64, 64),  '1,            128'h1008, 1'b0));
        exp_q.push_back(mk(bytes_seq(128, 32), 64'hFFFF_FFFF, 128'h1010, 1'b1));
        for (int k = 0; k < 20; k++) send(BASE + 64'(k) * INC, 8'hFF, 128'h1000 + 128'(k), k == 19);
        idle();

        // Backpressure on a completed word, then streaming release
        @(negedge clk) m_if.tready = 1'b0;
        exp_q.push_back(mk(bytes_seq(0, 64),  '1, 128'h2000, 1'b0));
        exp_q.push_back(mk(bytes_seq(64, 64), '1, 128'h2008, 1'b1));
        fork
            begin
                for (int k = 0; k < 16; k++) send(BASE + 64'(k) * INC, 8'hFF, 128'h2000 + 128'(k), k == 15);
                idle();
            end
            begin
                t = 0;
                do begin
                    @(negedge clk); #2; t++;
                end while (!m_if.tvalid && t < 50);
                chk("bp_word_seen", m_if.tvalid, 1);
                for (int c = 0; c < 5; c++) begin
                    if (c > 0) begin
                        @(negedge clk); #2;
                    end
                    chk("bp_s_tready_low", s_if.tready, 0);
                    chk("bp_tvalid_held",  m_if.tvalid, 1);
                    chk("bp_tdata_stable", m_if.tdata, bytes_seq(0, 64));
                end
                @(negedge clk);
                m_if.tready = 1'b1;
                acc0 = acc_cnt;
                #1 chk("bp_release_ready", s_if.tready, 1);
                repeat (8) @(posedge clk);
                #1 chk("bp_no_gap", 512'(acc_cnt - acc0), 8);
            end
        join
        repeat (2) @(negedge clk);

        // Sparse non-last beat, then empty-keep last beat
        chk("sparse_initially_clear", sparse_err, 0);
        exp_q.push_back(mk(512'({64'h2222222222222222, 64'h1111111111111111}),
                           64'hFF0F, 128'h3000, 1'b1));
        send(64'h1111111111111111, 8'h0F, 128'h3000, 1'b0);
        #1 chk("sparse_set", sparse_err, 1);
        send(64'h2222222222222222, 8'hFF, 128'h3001, 1'b1);
        idle();
        exp_q.push_back(mk('0, '0, 128'h4000, 1'b1));
        send(64'h0, 8'h00, 128'h4000, 1'b1);
        idle();
        repeat (3) @(negedge clk);
        chk("sparse_sticky", sparse_err, 1);

        // Reset mid-word
        for (int k = 0; k < 3; k++) send(64'hDEAD0000 + 64'(k), 8'hFF, 128'h77, 1'b0);
        @(negedge clk);
        s_if.tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 chk_outputs_zero("midreset");
        @(negedge clk) rst = 1'b0;
        exp_q.push_back(mk(512'(64'hCAFEF00D12345678), 64'hFF, 128'h5000, 1'b1));
        send(64'hCAFEF00D12345678, 8'hFF, 128'h5000, 1'b1);
        idle();

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 512'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
